// File: rtl/spi_ram_master_if.sv
// Host-side request/response signals plus the three SPI pins of the RAM wrapper.
// The master modport is the design's view; the slave modport is the host/bench view.
interface spi_ram_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] payload;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, cmd, payload, MISO,
    output busy, done, rd_data, rd_valid, SS_n, MOSI
  );

  modport slave (
    output start, cmd, payload, MISO,
    input  busy, done, rd_data, rd_valid, SS_n, MOSI
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master for the SPI-slave/RAM wrapper: shifts out an 11-bit command frame and,
// for RD_DATA, shifts in an 8-bit reply after a turnaround. SCLK is clk itself.
module spi_ram_master #(
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_ram_master_if.master      bus,
  output logic [2:0]            state_dbg
);

  // Handshake: start is sampled only while busy is low (IDLE); a request seen then is
  // accepted on that rising edge, and done (plus rd_valid for reads) pulses once at the end.
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_END} state_t;

  localparam logic [7:0] SEND_LAST = 8'd10;
  localparam logic [7:0] WAIT_LAST = 8'(TURNAROUND - 1);
  localparam logic [7:0] RECV_LAST = 8'd7;
  localparam logic [7:0] END_LAST  = 8'(IDLE_GAP - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [10:0] sh, sh_nxt;
  logic        rd_cmd, rd_cmd_nxt;
  logic [7:0]  rx, rx_nxt;
  logic [7:0]  rd_data_q, rd_data_nxt;
  logic        ss_n_q, ss_n_nxt;
  logic        mosi_q, mosi_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic        rv_q, rv_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      sh        <= 11'd0;
      rd_cmd    <= 1'b0;
      rx        <= 8'd0;
      rd_data_q <= 8'd0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sh        <= sh_nxt;
      rd_cmd    <= rd_cmd_nxt;
      rx        <= rx_nxt;
      rd_data_q <= rd_data_nxt;
      ss_n_q    <= ss_n_nxt;
      mosi_q    <= mosi_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      rv_q      <= rv_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sh_nxt      = sh;
    rd_cmd_nxt  = rd_cmd;
    rx_nxt      = rx;
    rd_data_nxt = rd_data_q;
    ss_n_nxt    = ss_n_q;
    mosi_nxt    = 1'b0;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    rv_nxt      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ss_n_nxt = 1'b1;
        busy_nxt = 1'b0;
        if (bus.start) begin
          // Frame is {cmd[1], cmd[1], cmd[0], payload}; its MSB goes out on the accept edge.
          state_nxt  = S_SEND;
          cnt_nxt    = 8'd0;
          sh_nxt     = {bus.cmd[1], bus.cmd[0], bus.payload, 1'b0};
          mosi_nxt   = bus.cmd[1];
          ss_n_nxt   = 1'b0;
          busy_nxt   = 1'b1;
          rd_cmd_nxt = (bus.cmd == 2'b11);
        end
      end
      S_SEND: begin
        ss_n_nxt = 1'b0;
        if (cnt == SEND_LAST) begin
          cnt_nxt = 8'd0;
          if (rd_cmd) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_END;
            ss_n_nxt  = 1'b1;
            done_nxt  = 1'b1;
          end
        end else begin
          mosi_nxt = sh[10];
          sh_nxt   = {sh[9:0], 1'b0};
          cnt_nxt  = cnt + 8'd1;
        end
      end
      S_WAIT: begin
        ss_n_nxt = 1'b0;
        if (cnt == WAIT_LAST) begin
          state_nxt = S_RECV;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_RECV: begin
        // MISO is only looked at here, so an undriven line elsewhere never reaches an output.
        ss_n_nxt = 1'b0;
        rx_nxt   = {rx[6:0], bus.MISO};
        if (cnt == RECV_LAST) begin
          state_nxt   = S_END;
          cnt_nxt     = 8'd0;
          ss_n_nxt    = 1'b1;
          done_nxt    = 1'b1;
          rv_nxt      = 1'b1;
          rd_data_nxt = {rx[6:0], bus.MISO};
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_END: begin
        ss_n_nxt = 1'b1;
        if (cnt == END_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rv_q;
  assign bus.rd_data  = rd_data_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: host driver, behavioural SPI RAM slave on the pins,
// and a monitor that checks frames and responses against a queued reference.
module tb_spi_ram_master;
  localparam int TA  = 2;
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;

  spi_ram_master_if bus ();

  spi_ram_master #(.TURNAROUND(TA), .IDLE_GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: RAM contents and pointers implied by the commands issued so far.
  logic [10:0] exp_frame_q[$];
  logic [15:0] exp_q[$];          // {latency[6:0], rd_valid, rd_data}
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_wa = 8'd0, ref_ra = 8'd0, ref_rd = 8'd0;

  // Behavioural slave: decodes frames from the pins and answers RD_DATA from its own RAM.
  logic [7:0]  s_mem [256];
  logic [7:0]  s_wa = 8'd0, s_ra = 8'd0, s_reply = 8'd0;
  logic [10:0] s_bits = 11'd0;
  int          s_n = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i * 7 + 3);
      s_mem[i]   = 8'(i * 7 + 3);
    end
  end

  task automatic expect_frame(input logic [1:0] c, input logic [7:0] p);
    int lat;
    exp_frame_q.push_back({c[1], c[1], c[0], p});
    lat = (c == 2'b11) ? 12 + TA + 8 : 12;
    case (c)
      2'b00: ref_wa = p;
      2'b01: ref_mem[ref_wa] = p;
      2'b10: ref_ra = p;
      default: ref_rd = ref_mem[ref_ra];
    endcase
    exp_q.push_back({7'(lat), (c == 2'b11), ref_rd});
  endtask

  always @(negedge clk) begin
    if (rst || bus.SS_n) begin
      s_n = 0;
    end else begin
      s_n++;
      if (s_n <= 11) s_bits = {s_bits[9:0], bus.MOSI};
      if (s_n == 11) begin
        case (s_bits[9:8])
          2'b00: s_wa = s_bits[7:0];
          2'b01: s_mem[s_wa] = s_bits[7:0];
          2'b10: s_ra = s_bits[7:0];
          default: s_reply = s_mem[s_ra];
        endcase
      end
    end
    if (s_n >= 12 + TA && s_n <= 19 + TA) bus.MISO = s_reply[19 + TA - s_n];
    else bus.MISO = 1'($urandom);
  end

  // Monitor
  int          mon_n = 0;
  bit          mon_on = 1'b0;
  logic [10:0] mon_bits = 11'd0;
  int          post_cnt = 0;
  int          ss_high = 100;
  int          done_cnt = 0;
  logic [10:0] ef;
  logic [15:0] er;

  always @(negedge clk) begin
    if (rst) begin
      mon_on   = 1'b0;
      post_cnt = 0;
      ss_high  = 100;
    end else begin
      if (!mon_on && !bus.SS_n) begin
        check("ss_high_gap", (ss_high >= GAP), 1'b1);
        mon_on = 1'b1;
        mon_n  = 0;
      end
      if (post_cnt > 0) begin
        post_cnt--;
        if (post_cnt == 0) check("busy_low_after_end", bus.busy, 1'b0);
      end
      if (mon_on) begin
        mon_n++;
        if (mon_n <= 11) begin
          check("ss_low_in_frame", bus.SS_n, 1'b0);
          mon_bits = {mon_bits[9:0], bus.MOSI};
          if (mon_n == 11) begin
            check("frame_pending", (exp_frame_q.size() != 0), 1'b1);
            if (exp_frame_q.size() != 0) begin
              ef = exp_frame_q.pop_front();
              check("mosi_frame", mon_bits, ef);
            end
          end
        end else if (!bus.SS_n) begin
          check("mosi_low_after_frame", bus.MOSI, 1'b0);
        end
        if (bus.done) begin
          done_cnt++;
          check("resp_pending", (exp_q.size() != 0), 1'b1);
          if (exp_q.size() != 0) begin
            er = exp_q.pop_front();
            check("done_latency", mon_n, er[15:9]);
            check("rd_valid", bus.rd_valid, er[8]);
            check("rd_data", bus.rd_data, er[7:0]);
            check("busy_in_end", bus.busy, 1'b1);
          end
          mon_on   = 1'b0;
          post_cnt = GAP;
        end else if (mon_n > 60) begin
          check("done_timeout", mon_n, 60);
          mon_on = 1'b0;
        end
      end
      ss_high = bus.SS_n ? ss_high + 1 : 0;
    end
  end

  // Driver tasks
  task automatic send(input logic [1:0] c, input logic [7:0] p);
    int guard = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("idle_wait_timeout", guard, 199);
    bus.start   = 1'b1;
    bus.cmd     = c;
    bus.payload = p;
    expect_frame(c, p);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.cmd     = 2'($urandom);
    bus.payload = 8'($urandom);
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((bus.busy !== 1'b0 || exp_q.size() != 0) && guard < 500);
    if (guard >= 500) check("drain_timeout", guard, 0);
  endtask

  task automatic run_continuous(input int nframes);
    int acc = 0, since = 0, guard = 0, period = 0;
    logic [1:0] c;
    logic [7:0] p;
    while (acc < nframes && guard < 2000) begin
      @(negedge clk);
      guard++;
      since++;
      c = 2'($urandom);
      p = 8'($urandom);
      bus.cmd     = c;
      bus.payload = p;
      bus.start   = 1'b1;
      if (bus.busy === 1'b0) begin
        if (acc > 0) check("start_period", since, period);
        expect_frame(c, p);
        period = (c == 2'b11) ? 20 + TA + GAP : 12 + GAP;
        since  = 0;
        acc++;
      end
    end
    if (guard >= 2000) check("continuous_timeout", acc, nframes);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int dc0;
    bus.start   = 1'b0;
    bus.cmd     = 2'b00;
    bus.payload = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ss_n", bus.SS_n, 1'b1);
    check("reset_mosi", bus.MOSI, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_rd_valid", bus.rd_valid, 1'b0);
    check("reset_rd_data", bus.rd_data, 8'h00);
    rst = 1'b0;

    send(2'b00, 8'hFF);
    send(2'b01, 8'hA5);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);

    send(2'b00, 8'h10);
    send(2'b01, 8'h3C);
    send(2'b10, 8'h10);
    send(2'b11, 8'h99);
    send(2'b00, 8'h77);
    wait_idle();

    dc0 = done_cnt;
    send(2'b00, 8'h00);
    send(2'b01, 8'h5A);
    wait_idle();
    check("b2b_done_count", done_cnt - dc0, 2);

    // Reset in the middle of a WR_DATA frame: nothing is expected from it.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cmd     = 2'b01;
    bus.payload = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_ss_n", bus.SS_n, 1'b1);
    check("midreset_mosi", bus.MOSI, 1'b0);
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_done", bus.done, 1'b0);
    check("midreset_rd_data", bus.rd_data, 8'h00);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    ref_rd = 8'h00;

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(2'($urandom), 8'($urandom));
    end
    wait_idle();

    run_continuous(8);
    wait_idle();

    check("frames_left", exp_frame_q.size(), 0);
    check("responses_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
